dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder end of the core's data-memory interface: accepts the core's dmem_addr/wdata/wstrb/we/re requests and returns dmem_rdata in the same cycle.
- Backs a word-addressed RAM plus a small MMIO window:
  - byte TX FIFO drained by a valid/ready sink;
  - coherent 64-bit cycle counter;
  - TOHOST completion register for test termination.
- Instantiated beside the core in the SoC top; the core's MEM stage depends on zero-wait combinational read data.

Parameters:
- XLEN, 32, address/data width; only 32 is supported.
- RAM_WORDS, 1024, RAM depth in 32-bit words (power of two); RAM occupies bytes 0 .. RAM_WORDS*4-1.
- MMIO_BASE, 32'h1000_0000, byte base of the MMIO window (64-byte aligned).
- TX_DEPTH, 8, TX FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- dmem_addr  in  XLEN  byte address; bits [1:0] ignored.
- dmem_wdata  in  32  write data, lane-aligned.
- dmem_wstrb  in  4  byte-lane write enables.
- dmem_we  in  1  write request this cycle.
- dmem_re  in  1  read request this cycle.
- dmem_rdata  out  32  combinational read data.
- tx_valid  out  1  FIFO head valid.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  sink accepts head this cycle.
- tohost_valid  out  1  sticky; set by a write to TOHOST.
- tohost_data  out  32  last value written to TOHOST.
- bus_err  out  1  one-cycle pulse, registered, for an unmapped access.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO emptied, so tx_valid=0.
  - cycle counter=0, HI snapshot=0, overflow bit=0.
  - tohost_valid=0, tohost_data=0, bus_err=0.
  - RAM contents are not cleared.
  - Reset during a pending request discards the request.
- Decode, using word address A = dmem_addr[XLEN-1:2]:
  - RAM if dmem_addr < RAM_WORDS*4; index A[log2(RAM_WORDS)-1:0].
  - MMIO if MMIO_BASE <= dmem_addr < MMIO_BASE+64; offset = dmem_addr[5:2].
  - Anything else is unmapped.
- Read:
  - When dmem_re=1, dmem_rdata is a combinational function of the current state.
  - When dmem_re=0, dmem_rdata=0.
  - An unmapped read returns 0.
- Write:
  - Commits at the edge when dmem_we=1.
  - RAM: only lanes with wstrb[i]=1 are updated.
  - If we=1 and re=1 to the same word in one cycle, rdata shows the pre-write value.
- bus_err: registered as (we|re) & unmapped, so it is high for exactly the cycle after the access.
- MMIO map (offsets in words). Reads of undefined offsets return 0; writes to them are ignored and do not raise bus_err.
  - 0 TX_DATA, write-only: if wstrb[0]=1, push wdata[7:0]; reads return 0.
  - 1 STATUS, read-only: bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] occupancy count.
  - 2 CYCLE_LO: returns counter[31:0]; a read (re=1) latches counter[63:32] into the HI snapshot at that edge.
  - 3 CYCLE_HI: returns the HI snapshot, not the live value.
  - 4 TOHOST: a write with wstrb=4'hF sets tohost_data=wdata and tohost_valid=1. Partial-strobe writes are ignored. Reads return tohost_data.
  - 5 STATUS_CLR: a write with wdata[2]=1 clears the overflow bit.
- Cycle counter:
  - 64-bit, increments every non-reset cycle, wraps 2^64-1 -> 0.
  - The value returned by CYCLE_LO is the pre-increment value for that cycle.
- TX FIFO:
  - pop = tx_valid & tx_ready.
  - push = TX_DATA write with wstrb[0]=1.
  - Push while full with no pop in the same cycle: byte dropped and overflow set.
  - Push and pop in the same cycle when full: both occur and count is unchanged.
  - Push and pop in the same cycle when empty: push only (no fall-through), and tx_valid rises next cycle.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - Pointers wrap modulo TX_DEPTH.
  - Push-to-tx_valid latency is 1 cycle.
- tohost_valid is held until reset; a later TOHOST write updates tohost_data.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- When defined:
  - Adds 32-bit wrapping counters at MMIO offset 6 LOADS and offset 7 STORES.
  - LOADS increments on each mapped read; STORES increments on each mapped write.
  - Both reset to 0; a write of any value to either offset clears it.
- When undefined: offsets 6 and 7 read 0, writes are ignored, and no counter flops are generated.

Test Plan:
- RAM strobes: write 0xAABBCCDD to 0x40 with wstrb=4'hF, then 0x11 with wstrb=4'b0010 -> read 0x40 returns 0xAABB11DD; re=0 -> rdata=0.
- Same-word read-during-write: we=1 and re=1 at 0x40 with new data 0x0 -> rdata shows 0xAABB11DD that cycle and 0x0 the next cycle.
- FIFO back-pressure:
  - With tx_ready=0, push 9 bytes 0x01..0x09 -> STATUS shows full, count=8, overflow=1.
  - Raise tx_ready -> 0x01..0x08 are drained in order.
  - At a full FIFO, simultaneous push and pop keeps count at 8.
- Cycle coherence: after reset, preload the counter near 0x0000_0000_FFFF_FFFE by running cycles (or force it) and read LO then HI across the wrap -> the HI snapshot matches the LO read's epoch.
- TOHOST and errors:
  - Write 0x1 with wstrb=4'h3 -> ignored.
  - Write 0x1 with wstrb=4'hF -> tohost_valid=1, tohost_data=1.
  - Read 0x2000_0000 -> rdata=0, with bus_err high for exactly one cycle.
- Reset mid-activity: FIFO holding 3 bytes and tohost_valid=1, assert rst for one edge -> tx_valid=0, STATUS=0x0000_0002, tohost_valid=0, RAM data preserved.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-wait word RAM plus an MMIO window (TX FIFO, cycle counter, TOHOST).
// Optional LOADS/STORES counters at MMIO offsets 6/7 when DMEM_PERF_CNT_EN is defined.
module dmem_responder #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int unsigned TX_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [31:0]     dmem_wdata,
    input  logic [3:0]      dmem_wstrb,
    input  logic            dmem_we,
    input  logic            dmem_re,
    output logic [31:0]     dmem_rdata,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            tohost_valid,
    output logic [31:0]     tohost_data,
    output logic            bus_err
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned PTR_W  = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(RAM_WORDS * 4);
    localparam logic [XLEN-1:0] MMIO_END  = MMIO_BASE + 32'd64;

    localparam logic [3:0] OFF_TX_DATA = 4'd0;
    localparam logic [3:0] OFF_STATUS  = 4'd1;
    localparam logic [3:0] OFF_CYC_LO  = 4'd2;
    localparam logic [3:0] OFF_CYC_HI  = 4'd3;
    localparam logic [3:0] OFF_TOHOST  = 4'd4;
    localparam logic [3:0] OFF_STS_CLR = 4'd5;
`ifdef DMEM_PERF_CNT_EN
    localparam logic [3:0] OFF_LOADS   = 4'd6;
    localparam logic [3:0] OFF_STORES  = 4'd7;
`endif

    // Storage
    logic [31:0]      ram_q  [RAM_WORDS];
    logic [7:0]       fifo_q [TX_DEPTH];

    // Control state
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             ovf_q,     ovf_d;
    logic [63:0]      cycle_q,   cycle_d;
    logic [31:0]      cyc_hi_q,  cyc_hi_d;
    logic             tohost_valid_q, tohost_valid_d;
    logic [31:0]      tohost_data_q,  tohost_data_d;
    logic             bus_err_q, bus_err_d;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0]      loads_q,   loads_d;
    logic [31:0]      stores_q,  stores_d;
`endif

    // Decode
    logic              ram_hit;
    logic              mmio_hit;
    logic              unmapped;
    logic [3:0]        mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_wr;
    logic              mmio_wr;
    logic              tx_push_req;
    logic              tx_pop;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              tohost_wr;
    logic              ovf_clr;
    logic              lo_rd;
    logic [31:0]       status_word;
    logic [31:0]       mmio_rdata;

    assign ram_hit     = (dmem_addr < RAM_BYTES);
    assign mmio_hit    = (dmem_addr >= MMIO_BASE) && (dmem_addr < MMIO_END);
    assign unmapped    = !ram_hit && !mmio_hit;
    assign mmio_off    = dmem_addr[5:2];
    assign ram_idx     = dmem_addr[RAM_AW+1:2];

    assign ram_wr      = dmem_we && ram_hit;
    assign mmio_wr     = dmem_we && mmio_hit;
    assign tx_push_req = mmio_wr && (mmio_off == OFF_TX_DATA) && dmem_wstrb[0];
    assign tohost_wr   = mmio_wr && (mmio_off == OFF_TOHOST) && (dmem_wstrb == 4'hF);
    assign ovf_clr     = mmio_wr && (mmio_off == OFF_STS_CLR) && dmem_wdata[2];
    assign lo_rd       = dmem_re && mmio_hit && (mmio_off == OFF_CYC_LO);

    assign fifo_full   = (count_q == CNT_W'(TX_DEPTH));
    assign fifo_empty  = (count_q == {CNT_W{1'b0}});
    assign tx_pop      = tx_valid && tx_ready;
    // A push at a full FIFO only lands if the head leaves in the same cycle.
    assign push_ok     = tx_push_req && (!fifo_full || tx_pop);

    assign status_word = {16'd0, 8'(count_q), 5'd0, ovf_q, fifo_empty, fifo_full};

    assign tx_valid     = !fifo_empty;
    assign tx_data      = fifo_q[rd_ptr_q];
    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_data_q;
    assign bus_err      = bus_err_q;

    // MMIO read mux
    always_comb begin
        mmio_rdata = 32'd0;
        case (mmio_off)
            OFF_TX_DATA: mmio_rdata = 32'd0;
            OFF_STATUS:  mmio_rdata = status_word;
            OFF_CYC_LO:  mmio_rdata = cycle_q[31:0];
            OFF_CYC_HI:  mmio_rdata = cyc_hi_q;
            OFF_TOHOST:  mmio_rdata = tohost_data_q;
`ifdef DMEM_PERF_CNT_EN
            OFF_LOADS:   mmio_rdata = loads_q;
            OFF_STORES:  mmio_rdata = stores_q;
`endif
            default:     mmio_rdata = 32'd0;
        endcase
    end

    // Combinational read data; array read gives the pre-write value on a same-cycle write
    always_comb begin
        dmem_rdata = 32'd0;
        if (dmem_re) begin
            if (ram_hit) begin
                dmem_rdata = ram_q[ram_idx];
            end else if (mmio_hit) begin
                dmem_rdata = mmio_rdata;
            end else begin
                dmem_rdata = 32'd0;
            end
        end else begin
            dmem_rdata = 32'd0;
        end
    end

    // Next-state for FIFO pointers, flags, counter and TOHOST
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        ovf_d          = ovf_q;
        cycle_d        = cycle_q + 64'd1;
        cyc_hi_d       = cyc_hi_q;
        tohost_valid_d = tohost_valid_q;
        tohost_data_d  = tohost_data_q;
        bus_err_d      = (dmem_we || dmem_re) && unmapped;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok && !tx_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && tx_pop) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        if (tx_push_req && fifo_full && !tx_pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // Snapshot taken from the same pre-increment value that CYCLE_LO returns
        if (lo_rd) begin
            cyc_hi_d = cycle_q[63:32];
        end else begin
            cyc_hi_d = cyc_hi_q;
        end

        if (tohost_wr) begin
            tohost_valid_d = 1'b1;
            tohost_data_d  = dmem_wdata;
        end else begin
            tohost_valid_d = tohost_valid_q;
            tohost_data_d  = tohost_data_q;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    // Next-state for access counters; a write to a counter clears it
    always_comb begin
        loads_d  = loads_q;
        stores_d = stores_q;
        if (mmio_wr && (mmio_off == OFF_LOADS)) begin
            loads_d = 32'd0;
        end else if (dmem_re && !unmapped) begin
            loads_d = loads_q + 32'd1;
        end else begin
            loads_d = loads_q;
        end
        if (mmio_wr && (mmio_off == OFF_STORES)) begin
            stores_d = 32'd0;
        end else if (dmem_we && !unmapped) begin
            stores_d = stores_q + 32'd1;
        end else begin
            stores_d = stores_q;
        end
    end

    // Access counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            loads_q  <= 32'd0;
            stores_q <= 32'd0;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
        end
    end
`endif

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= {PTR_W{1'b0}};
            rd_ptr_q       <= {PTR_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            ovf_q          <= 1'b0;
            cycle_q        <= 64'd0;
            cyc_hi_q       <= 32'd0;
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= 32'd0;
            bus_err_q      <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            cycle_q        <= cycle_d;
            cyc_hi_q       <= cyc_hi_d;
            tohost_valid_q <= tohost_valid_d;
            tohost_data_q  <= tohost_data_d;
            bus_err_q      <= bus_err_d;
        end
    end

    // FIFO storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_q[wr_ptr_q] <= dmem_wdata[7:0];
        end
    end

    // RAM byte-lane write; contents survive reset, but a write during reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wstrb[i]) begin
                    ram_q[ram_idx][i*8 +: 8] <= dmem_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule
